// File: rtl/dts_sync_arm.sv
// DTS per-lane timing-pulse checker: collects enabled-lane pulses in a short window,
// counts clean/errored events, measures the event period and emits an armed one-shot sync.
module dts_sync_arm #(
    parameter int N_INPUTS    = 12,
    parameter int SKEW_WINDOW = 4,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_INPUTS-1:0]  one_sec,
    input  logic [N_INPUTS-1:0]  ten_sec,
    input  logic [N_INPUTS-1:0]  lane_mask,
    input  logic                 trig_src,
    input  logic                 arm,
    input  logic                 disarm,
    input  logic                 clr_cnt,
    output logic                 sync_out,
    output logic                 armed,
    output logic                 skew_err,
    output logic [N_INPUTS-1:0]  lanes_seen,
    output logic [31:0]          event_cnt,
    output logic [15:0]          skew_err_cnt,
    output logic [CNT_WIDTH-1:0] pps_period,
    output logic                 period_valid
);

    typedef enum logic {COL_IDLE, COL_COLLECT} col_state_e;
    typedef enum logic {ARM_OFF, ARM_ON} arm_state_e;

    localparam logic [3:0] WIN_LEN = 4'(SKEW_WINDOW);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc_cnt(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + CNT_WIDTH'(1);
    endfunction

    logic [N_INPUTS-1:0]  one_sec_q, ten_sec_q, mask_q;
    logic                 src_q;

    col_state_e           col_q, col_d;
    logic [3:0]           wcnt_q, wcnt_d;
    logic [N_INPUTS-1:0]  seen_q, seen_d;
    logic [N_INPUTS-1:0]  win_mask_q, win_mask_d;
    logic                 win_src_q, win_src_d;

    arm_state_e           arm_q, arm_d;
    logic                 sync_q, sync_d;
    logic                 skew_q, skew_d;
    logic [N_INPUTS-1:0]  lanes_q, lanes_d;
    logic [31:0]          event_cnt_q, event_cnt_d;
    logic [15:0]          skew_err_cnt_q, skew_err_cnt_d;
    logic [CNT_WIDTH-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_WIDTH-1:0] pps_q, pps_d;
    logic                 started_q, started_d;
    logic                 pvalid_q, pvalid_d;

    logic [N_INPUTS-1:0]  p_start, p_win;
    logic                 win_close, win_clean, win_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            one_sec_q <= '0;
            ten_sec_q <= '0;
            mask_q    <= '0;
            src_q     <= 1'b0;
        end else begin
            one_sec_q <= one_sec;
            ten_sec_q <= ten_sec;
            mask_q    <= lane_mask;
            src_q     <= trig_src;
        end
    end

    // A fresh window always uses the live source/mask; an open one uses its latched copy.
    always_comb begin
        p_start   = (src_q ? ten_sec_q : one_sec_q) & mask_q;
        p_win     = (win_src_q ? ten_sec_q : one_sec_q) & win_mask_q;
        win_close = (col_q == COL_COLLECT) && (wcnt_q == WIN_LEN);
        win_clean = win_close && (seen_q == win_mask_q);
        win_start = ((col_q == COL_IDLE) || win_close) && (p_start != '0);

        col_d      = col_q;
        wcnt_d     = wcnt_q;
        seen_d     = seen_q;
        win_mask_d = win_mask_q;
        win_src_d  = win_src_q;
        if (win_start) begin
            col_d      = COL_COLLECT;
            wcnt_d     = 4'd1;
            seen_d     = p_start;
            win_mask_d = mask_q;
            win_src_d  = src_q;
        end else if (win_close) begin
            col_d = COL_IDLE;
        end else if (col_q == COL_COLLECT) begin
            seen_d = seen_q | p_win;
            wcnt_d = wcnt_q + 4'd1;
        end

        sync_d  = win_clean && (arm_q == ARM_ON);
        skew_d  = win_close && !win_clean;
        lanes_d = win_close ? seen_q : lanes_q;

        arm_d = arm_q;
        if (disarm)      arm_d = ARM_OFF;
        else if (sync_d) arm_d = ARM_OFF;
        else if (arm)    arm_d = ARM_ON;

        event_cnt_d    = event_cnt_q;
        skew_err_cnt_d = skew_err_cnt_q;
        if (clr_cnt) begin
            event_cnt_d    = '0;
            skew_err_cnt_d = '0;
        end else begin
            if (win_clean) event_cnt_d = event_cnt_q + 32'd1;
            if (skew_d)    skew_err_cnt_d = sat_inc16(skew_err_cnt_q);
        end

        per_cnt_d = sat_inc_cnt(per_cnt_q);
        pps_d     = pps_q;
        started_d = started_q;
        pvalid_d  = pvalid_q;
        if (win_start) begin
            per_cnt_d = '0;
            pps_d     = sat_inc_cnt(per_cnt_q);
            started_d = 1'b1;
            pvalid_d  = pvalid_q | started_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q          <= COL_IDLE;
            wcnt_q         <= '0;
            seen_q         <= '0;
            win_mask_q     <= '0;
            win_src_q      <= 1'b0;
            arm_q          <= ARM_OFF;
            sync_q         <= 1'b0;
            skew_q         <= 1'b0;
            lanes_q        <= '0;
            event_cnt_q    <= '0;
            skew_err_cnt_q <= '0;
            per_cnt_q      <= '0;
            pps_q          <= '0;
            started_q      <= 1'b0;
            pvalid_q       <= 1'b0;
        end else begin
            col_q          <= col_d;
            wcnt_q         <= wcnt_d;
            seen_q         <= seen_d;
            win_mask_q     <= win_mask_d;
            win_src_q      <= win_src_d;
            arm_q          <= arm_d;
            sync_q         <= sync_d;
            skew_q         <= skew_d;
            lanes_q        <= lanes_d;
            event_cnt_q    <= event_cnt_d;
            skew_err_cnt_q <= skew_err_cnt_d;
            per_cnt_q      <= per_cnt_d;
            pps_q          <= pps_d;
            started_q      <= started_d;
            pvalid_q       <= pvalid_d;
        end
    end

    assign sync_out     = sync_q;
    assign armed        = (arm_q == ARM_ON);
    assign skew_err     = skew_q;
    assign lanes_seen   = lanes_q;
    assign event_cnt    = event_cnt_q;
    assign skew_err_cnt = skew_err_cnt_q;
    assign pps_period   = pps_q;
    assign period_valid = pvalid_q;

endmodule

// File: tb/tb_dts_sync_arm.sv
// Bench for dts_sync_arm: directed scenarios plus random traffic against a window-level model.
module tb_dts_sync_arm;
    localparam int N = 12;
    localparam int W = 4;

    logic clk;
    logic rst;
    logic [N-1:0] one_sec, ten_sec, lane_mask;
    logic trig_src, arm, disarm, clr_cnt;
    logic sync_out, armed, skew_err, period_valid;
    logic [N-1:0] lanes_seen;
    logic [31:0] event_cnt, pps_period;
    logic [15:0] skew_err_cnt;

    int vectors = 0;
    int miscompares = 0;

    dts_sync_arm #(.N_INPUTS(N), .SKEW_WINDOW(W), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .one_sec(one_sec), .ten_sec(ten_sec),
        .lane_mask(lane_mask), .trig_src(trig_src), .arm(arm), .disarm(disarm),
        .clr_cnt(clr_cnt), .sync_out(sync_out), .armed(armed), .skew_err(skew_err),
        .lanes_seen(lanes_seen), .event_cnt(event_cnt), .skew_err_cnt(skew_err_cnt),
        .pps_period(pps_period), .period_valid(period_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: windows tracked by their opening sample edge; results land one edge after closing.
    int cyc = 0, prev_s = 0, m_t = 0;
    bit m_open, m_started, pc_v, ps_v;
    logic m_wsrc;
    logic [N-1:0] m_wmask, m_seen, pc_seen, pc_mask;
    logic e_sync, e_armed, e_skew, e_pv;
    logic [N-1:0] e_lanes;
    logic [31:0] e_evt, e_pps;
    logic [15:0] e_skc;

    logic [95:0] dut_vec, exp_vec;
    assign dut_vec = {sync_out, armed, skew_err, lanes_seen, event_cnt, skew_err_cnt, pps_period, period_valid};
    assign exp_vec = {e_sync, e_armed, e_skew, e_lanes, e_evt, e_skc, e_pps, e_pv};

    task automatic model_clear();
        m_open = 0; m_started = 0; pc_v = 0; ps_v = 0;
        e_sync = 0; e_armed = 0; e_skew = 0; e_pv = 0;
        e_lanes = '0; e_evt = '0; e_pps = '0; e_skc = '0;
        prev_s = cyc;
    endtask

    task automatic model_update();
        logic [N-1:0] sel_now;
        bit clean, nc_v, ns_v;
        logic [N-1:0] nc_seen, nc_mask;
        cyc++;
        if (rst) begin
            model_clear();
            return;
        end
        clean  = pc_v && (pc_seen == pc_mask);
        e_sync = clean && e_armed;
        e_skew = pc_v && !clean;
        if (pc_v) e_lanes = pc_seen;
        if (clr_cnt) begin
            e_evt = '0; e_skc = '0;
        end else begin
            if (clean) e_evt = e_evt + 1;
            if (e_skew && e_skc != 16'hFFFF) e_skc = e_skc + 1;
        end
        if (disarm) e_armed = 0;
        else if (e_sync) e_armed = 0;
        else if (arm) e_armed = 1;
        if (ps_v) begin
            e_pps = 32'(cyc - prev_s);
            prev_s = cyc;
            if (m_started) e_pv = 1;
            m_started = 1;
        end
        nc_v = 0; ns_v = 0; nc_seen = '0; nc_mask = '0;
        sel_now = (trig_src ? ten_sec : one_sec) & lane_mask;
        if (m_open && cyc < m_t + W) begin
            m_seen |= (m_wsrc ? ten_sec : one_sec) & m_wmask;
        end else if (m_open) begin
            nc_v = 1; nc_seen = m_seen; nc_mask = m_wmask; m_open = 0;
        end
        if (!m_open && sel_now != '0) begin
            m_open = 1; m_t = cyc; m_wsrc = trig_src; m_wmask = lane_mask; m_seen = sel_now; ns_v = 1;
        end
        pc_v = nc_v; pc_seen = nc_seen; pc_mask = nc_mask; ps_v = ns_v;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic drive_quiet();
        one_sec = '0; ten_sec = '0; arm = 0; disarm = 0; clr_cnt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_clear();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive_quiet();
        lane_mask = '0; trig_src = 0;
        do_reset();
        vectors++;
        if (dut_vec !== 96'd0) begin
            miscompares++;
            $display("FAIL reset_state got %h required 0", dut_vec);
        end
    endtask

    task automatic test_clean_sync();
        lane_mask = 12'hFFF; trig_src = 0;
        for (int c = 0; c <= 30; c++) begin
            drive_quiet();
            if (c == 5) arm = 1;
            if (c == 20) one_sec = 12'hFFF;
            tick();
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL clean_sync_model c=%0d got %h required %h", c, dut_vec, exp_vec);
            end
            if (c >= 20) begin
                vectors++;
                if (sync_out !== (c == 25)) begin
                    miscompares++;
                    $display("FAIL clean_sync_pulse c=%0d got %b required %b", c, sync_out, (c == 25));
                end
            end
            if (c == 26) begin
                vectors++;
                if (armed !== 1'b0 || event_cnt !== 32'd1 || lanes_seen !== 12'hFFF) begin
                    miscompares++;
                    $display("FAIL clean_sync_after got armed=%b cnt=%0d lanes=%h required 0 1 fff", armed, event_cnt, lanes_seen);
                end
            end
        end
    endtask

    task automatic test_skew_inside();
        for (int c = 0; c <= 30; c++) begin
            drive_quiet();
            if (c == 5) arm = 1;
            if (c == 20) one_sec = 12'h03F;
            if (c == 23) one_sec = 12'hFC0;
            tick();
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL skew_inside_model c=%0d got %h required %h", c, dut_vec, exp_vec);
            end
            if (c == 25) begin
                vectors++;
                if (sync_out !== 1'b1 || skew_err !== 1'b0 || event_cnt !== 32'd2) begin
                    miscompares++;
                    $display("FAIL skew_inside_sync got sync=%b err=%b cnt=%0d required 1 0 2", sync_out, skew_err, event_cnt);
                end
            end
        end
    endtask

    task automatic test_skew_outside();
        for (int c = 0; c <= 50; c++) begin
            drive_quiet();
            if (c == 5) arm = 1;
            if (c == 20) one_sec = 12'h7FF;
            if (c == 24) one_sec = 12'h800;
            if (c == 40) one_sec = 12'hFFF;
            tick();
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL skew_outside_model c=%0d got %h required %h", c, dut_vec, exp_vec);
            end
            if (c >= 20) begin
                vectors++;
                if (skew_err !== (c == 25 || c == 29) || sync_out !== (c == 45)) begin
                    miscompares++;
                    $display("FAIL skew_outside_pulses c=%0d got err=%b sync=%b", c, skew_err, sync_out);
                end
            end
            if (c == 25 || c == 29) begin
                vectors++;
                if (lanes_seen !== ((c == 25) ? 12'h7FF : 12'h800) || armed !== 1'b1) begin
                    miscompares++;
                    $display("FAIL skew_outside_lanes c=%0d got lanes=%h armed=%b", c, lanes_seen, armed);
                end
            end
        end
    endtask

    task automatic test_masked();
        lane_mask = 12'hFFE; trig_src = 0;
        for (int c = 0; c <= 40; c++) begin
            drive_quiet();
            if (c == 2) arm = 1;
            if (c == 10) one_sec = 12'hFFE;
            if (c == 20) ten_sec = 12'hFFF;
            if (c == 30) one_sec = 12'hFFF;
            tick();
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL masked_model c=%0d got %h required %h", c, dut_vec, exp_vec);
            end
            if (c >= 10) begin
                vectors++;
                if (skew_err !== 1'b0 || sync_out !== (c == 15)) begin
                    miscompares++;
                    $display("FAIL masked_pulses c=%0d got err=%b sync=%b", c, skew_err, sync_out);
                end
            end
        end
        vectors++;
        if (event_cnt !== 32'd5) begin
            miscompares++;
            $display("FAIL masked_count got %0d required 5", event_cnt);
        end
    endtask

    task automatic test_period();
        drive_quiet();
        do_reset();
        lane_mask = 12'hFFF; trig_src = 0;
        for (int c = 0; c <= 1110; c++) begin
            drive_quiet();
            if (c == 100 || c == 1100) one_sec = 12'hFFF;
            if (c == 200) begin arm = 1; disarm = 1; end
            tick();
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL period_model c=%0d got %h required %h", c, dut_vec, exp_vec);
            end
            if (c == 200) begin
                vectors++;
                if (armed !== 1'b0) begin
                    miscompares++;
                    $display("FAIL arm_disarm_same got %b required 0", armed);
                end
            end
            if (c == 1100 || c == 1101) begin
                vectors++;
                if (period_valid !== (c == 1101) || (c == 1101 && pps_period !== 32'd1000)) begin
                    miscompares++;
                    $display("FAIL period_value c=%0d got valid=%b period=%0d required %b 1000", c, period_valid, pps_period, (c == 1101));
                end
            end
        end
    endtask

    task automatic test_boundaries();
        // Reset in the middle of an armed window.
        drive_quiet();
        lane_mask = 12'hFFF; trig_src = 0;
        arm = 1; tick();
        drive_quiet(); one_sec = 12'hFFF; tick();
        drive_quiet(); tick();
        rst = 1'b1;
        model_clear();
        #1;
        vectors++;
        if (dut_vec !== 96'd0) begin
            miscompares++;
            $display("FAIL reset_mid_window got %h required 0", dut_vec);
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            vectors++;
            if (dut_vec !== 96'd0 || dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL reset_quiet c=%0d got %h required %h", c, dut_vec, exp_vec);
            end
        end

        // Errored event with the error counter already at its ceiling.
        force dut.skew_err_cnt_q = 16'hFFFF;
        e_skc = 16'hFFFF;
        tick();
        release dut.skew_err_cnt_q;
        for (int c = 0; c <= 10; c++) begin
            drive_quiet();
            if (c == 2) one_sec = 12'h001;
            tick();
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL saturate_model c=%0d got %h required %h", c, dut_vec, exp_vec);
            end
            if (c == 7 || c == 10) begin
                vectors++;
                if (skew_err !== (c == 7) || skew_err_cnt !== 16'hFFFF) begin
                    miscompares++;
                    $display("FAIL saturate_cnt c=%0d got err=%b cnt=%h required %b ffff", c, skew_err, skew_err_cnt, (c == 7));
                end
            end
        end

        // Clear landing on the same edge as a clean event.
        for (int c = 0; c <= 9; c++) begin
            drive_quiet();
            if (c == 2) one_sec = 12'hFFF;
            if (c == 7) clr_cnt = 1;
            tick();
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL clr_model c=%0d got %h required %h", c, dut_vec, exp_vec);
            end
            if (c == 7) begin
                vectors++;
                if (event_cnt !== 32'd0 || skew_err_cnt !== 16'd0) begin
                    miscompares++;
                    $display("FAIL clr_coincident got evt=%0d err=%0d required 0 0", event_cnt, skew_err_cnt);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] masks [4];
        int r;
        masks[0] = 12'hFFF; masks[1] = 12'hFFE; masks[2] = 12'h0F0; masks[3] = 12'h000;
        for (int c = 0; c < 3000; c++) begin
            drive_quiet();
            if ($urandom_range(0, 99) == 0) lane_mask = ($urandom_range(0, 4) == 4) ? 12'($urandom) : masks[$urandom_range(0, 3)];
            if ($urandom_range(0, 149) == 0) trig_src = ~trig_src;
            r = $urandom_range(0, 99);
            if (r < 4) one_sec = 12'hFFF;
            else if (r < 6) one_sec = 12'($urandom);
            r = $urandom_range(0, 99);
            if (r < 3) ten_sec = 12'hFFF;
            else if (r < 5) ten_sec = 12'($urandom);
            arm     = ($urandom_range(0, 29) == 0);
            disarm  = ($urandom_range(0, 89) == 0);
            clr_cnt = ($urandom_range(0, 249) == 0);
            tick();
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL random_model c=%0d got %h required %h", c, dut_vec, exp_vec);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        lane_mask = '0; trig_src = 0;
        drive_quiet();
        model_clear();
        @(negedge clk);
        test_reset();
        test_clean_sync();
        test_skew_inside();
        test_skew_outside();
        test_masked();
        test_period();
        test_boundaries();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
